// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target register file.
// Holds the target FSM state encoding and ACK/RW bit values.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RACK,
        WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes the SCL/SDA pad inputs and produces single-cycle event pulses.
// Ports: clk, reset (async high), scl_in, sda_in -> sda (synced level),
//        scl_rise, scl_fall, start_det, stop_det (1-cycle pulses).
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl;

    // Reset to the idle-bus level so no edge is seen right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_q    <= scl_sync[SYNC_STAGES-1];
            sda_q    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl = scl_sync[SYNC_STAGES-1];
    assign sda = sda_sync[SYNC_STAGES-1];

    assign scl_rise  = scl & ~scl_q;
    assign scl_fall  = ~scl & scl_q;
    // SDA edges only count as START/STOP when SCL was high on both samples.
    assign start_det = scl & scl_q & sda_q & ~sda;
    assign stop_det  = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a small register file: pointer write, burst write, burst read.
// Ports: clk, reset (async high), scl_in, sda_in, sda_oe (1=pull low), busy,
//        wr_valid/wr_ptr/wr_data (write strobe), dbg_ptr -> dbg_data (comb read).
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h55,
    parameter int         NUM_REGS    = 4,
    parameter int         PTR_W       = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             busy,
    output logic             wr_valid,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [7:0]       wr_data,
    input  logic [PTR_W-1:0] dbg_ptr,
    output logic [7:0]       dbg_data
);

    localparam logic [PTR_W-1:0] PTR_ONE = 1;

    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    i2c_bus_monitor #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_mon (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det)
    );

    i2c_tgt_state_t   state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic [6:0]       rx, rx_n;
    logic [6:0]       tx, tx_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             oe_n;
    logic             busy_n;
    logic             flag, flag_n;
    logic             rw, rw_n;
    logic             wr_valid_n;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [7:0]       wr_data_n;
    logic             we;
    logic [7:0]       rx_shift;
    logic [7:0]       rd_byte;
    logic [7:0]       regs [NUM_REGS];

    assign rx_shift = {rx, sda};
    assign rd_byte  = regs[ptr];
    assign dbg_data = regs[dbg_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            rx       <= '0;
            tx       <= '0;
            ptr      <= '0;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            flag     <= 1'b0;
            rw       <= I2C_WRITE;
            wr_valid <= 1'b0;
            wr_ptr   <= '0;
            wr_data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rx       <= rx_n;
            tx       <= tx_n;
            ptr      <= ptr_n;
            sda_oe   <= oe_n;
            busy     <= busy_n;
            flag     <= flag_n;
            rw       <= rw_n;
            wr_valid <= wr_valid_n;
            wr_ptr   <= wr_ptr_n;
            wr_data  <= wr_data_n;
            if (we) begin
                regs[ptr] <= rx_shift;
            end
        end
    end

    // flag: in *_ACK states it marks that the ACK is being driven;
    // in RACK it marks that the master acknowledged.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rx_n       = rx;
        tx_n       = tx;
        ptr_n      = ptr;
        oe_n       = sda_oe;
        busy_n     = busy;
        flag_n     = flag;
        rw_n       = rw;
        wr_valid_n = 1'b0;
        wr_ptr_n   = wr_ptr;
        wr_data_n  = wr_data;
        we         = 1'b0;

        if (stop_det) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
            flag_n  = 1'b0;
            cnt_n   = '0;
        end else if (start_det) begin
            state_n = ADDR;
            oe_n    = 1'b0;
            flag_n  = 1'b0;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE, WAIT_STOP: begin
                    oe_n = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift[6:0];
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n = '0;
                            if (rx_shift[7:1] == TARGET_ADDR) begin
                                state_n = ADDR_ACK;
                                busy_n  = 1'b1;
                                rw_n    = rx_shift[0];
                            end else begin
                                state_n = WAIT_STOP;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!flag) begin
                            oe_n   = ~I2C_ACK;
                            flag_n = 1'b1;
                        end else begin
                            flag_n = 1'b0;
                            oe_n   = 1'b0;
                            cnt_n  = '0;
                            if (state == ADDR_ACK && rw == I2C_READ) begin
                                // Release of the ACK is also the first data bit.
                                state_n = RDATA;
                                tx_n    = rd_byte[6:0];
                                oe_n    = ~rd_byte[7];
                            end else if (state == ADDR_ACK) begin
                                state_n = PTR;
                            end else begin
                                state_n = WDATA;
                            end
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift[6:0];
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n   = '0;
                            ptr_n   = rx_shift[PTR_W-1:0];
                            state_n = PTR_ACK;
                        end
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        rx_n  = rx_shift[6:0];
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            cnt_n      = '0;
                            we         = 1'b1;
                            wr_valid_n = 1'b1;
                            wr_ptr_n   = ptr;
                            wr_data_n  = rx_shift;
                            ptr_n      = ptr + PTR_ONE;
                            state_n    = WDATA_ACK;
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            cnt_n   = '0;
                            state_n = RACK;
                        end else begin
                            oe_n = ~tx[6];
                            tx_n = {tx[5:0], 1'b0};
                        end
                    end
                end
                RACK: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            ptr_n  = ptr + PTR_ONE;
                            flag_n = 1'b1;
                        end else begin
                            state_n = WAIT_STOP;
                            busy_n  = 1'b0;
                            oe_n    = 1'b0;
                        end
                    end else if (scl_fall && flag) begin
                        flag_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = RDATA;
                        tx_n    = rd_byte[6:0];
                        oe_n    = ~rd_byte[7];
                    end
                end
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bus-level I2C master driving the target register file.
// Write and read data are checked against scoreboard queues.
module tb_i2c_target_regfile;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic       busy;
    logic       wr_valid;
    logic [1:0] wr_ptr;
    logic [7:0] wr_data;
    logic [1:0] dbg_ptr = 2'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic       oe_prev = 1'b0;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .busy    (busy),
        .wr_valid(wr_valid),
        .wr_ptr  (wr_ptr),
        .wr_data (wr_data),
        .dbg_ptr (dbg_ptr),
        .dbg_data(dbg_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (sda_oe && !oe_prev && !reset) begin
            checks++;
            assert (scl == 1'b0) else begin
                failures++;
                $error("FAIL oe_rise_scl_high observed scl=%b expected 0", scl);
            end
        end
        oe_prev = sda_oe;
        if (wr_valid) begin
            checks++;
            assert (exp_wr.size() != 0) else begin
                failures++;
                $error("FAIL wr_unexpected observed ptr=%0d data=%h expected none",
                       wr_ptr, wr_data);
            end
            if (exp_wr.size() != 0) begin
                logic [9:0] e;
                e = exp_wr.pop_front();
                checks++;
                assert ({wr_ptr, wr_data} === e) else begin
                    failures++;
                    $error("FAIL wr_beat observed=%h expected=%h",
                           {wr_ptr, wr_data}, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b0; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl = 1'b1;   tick(Q);
        sda_m = 1'b1; tick(2 * Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; tick(Q);
            scl = 1'b1;   tick(2 * Q);
            scl = 1'b0;   tick(Q);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; tick(Q);
        scl = 1'b1;   tick(Q);
        ack = sda_bus; tick(Q);
        scl = 1'b0;   tick(Q);
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; tick(Q);
            scl = 1'b1;   tick(Q);
            b = {b[6:0], sda_bus}; tick(Q);
            scl = 1'b0;   tick(Q);
        end
        sda_m = ack; tick(Q);
        scl = 1'b1;  tick(2 * Q);
        scl = 1'b0;  tick(Q);
        sda_m = 1'b1;
    endtask

    task automatic dbg_chk(input string tag, input logic [1:0] p,
                           input logic [7:0] exp);
        dbg_ptr = p;
        #1;
        chk(tag, {8'h0, dbg_data}, {8'h0, exp});
    endtask

    initial begin
        logic       a;
        logic [7:0] rb;
        logic [7:0] e;
        int         n;

        tick(4);
        chk("rst_sda_oe", {15'h0, sda_oe}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_wr_valid", {15'h0, wr_valid}, 16'h0);
        chk("rst_wr_ptr", {14'h0, wr_ptr}, 16'h0);
        chk("rst_wr_data", {8'h0, wr_data}, 16'h0);
        for (int i = 0; i < 4; i++) dbg_chk("rst_reg", 2'(i), 8'h00);
        reset = 1'b0;
        tick(10);

        // Single write to register 1.
        i2c_start();
        send_byte(8'hAA, a); chk("wr_addr_ack", {15'h0, a}, 16'h0);
        chk("wr_busy", {15'h0, busy}, 16'h1);
        send_byte(8'h01, a); chk("wr_ptr_ack", {15'h0, a}, 16'h0);
        exp_wr.push_back({2'd1, 8'hA5});
        send_byte(8'hA5, a); chk("wr_data_ack", {15'h0, a}, 16'h0);
        i2c_stop();
        chk("wr_busy_after_stop", {15'h0, busy}, 16'h0);
        dbg_chk("wr_reg1", 2'd1, 8'hA5);

        // Burst write wrapping from register 3 to 0.
        i2c_start();
        send_byte(8'hAA, a); chk("bw_addr_ack", {15'h0, a}, 16'h0);
        send_byte(8'h03, a); chk("bw_ptr_ack", {15'h0, a}, 16'h0);
        exp_wr.push_back({2'd3, 8'h11});
        send_byte(8'h11, a); chk("bw_d0_ack", {15'h0, a}, 16'h0);
        exp_wr.push_back({2'd0, 8'h22});
        send_byte(8'h22, a); chk("bw_d1_ack", {15'h0, a}, 16'h0);
        i2c_stop();
        dbg_chk("bw_reg3", 2'd3, 8'h11);
        dbg_chk("bw_reg0", 2'd0, 8'h22);

        // Give register 2 a distinctive value for the read.
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h02, a);
        exp_wr.push_back({2'd2, 8'h3C});
        send_byte(8'h3C, a); chk("pre_d_ack", {15'h0, a}, 16'h0);
        i2c_stop();

        // Pointer set, repeated START, read two bytes.
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h01, a); chk("rd_ptr_ack", {15'h0, a}, 16'h0);
        i2c_start();
        send_byte(8'hAB, a); chk("rd_addr_ack", {15'h0, a}, 16'h0);
        exp_rd.push_back(8'hA5);
        exp_rd.push_back(8'h3C);
        recv_byte(1'b0, rb);
        e = exp_rd.pop_front();
        chk("rd_byte0", {8'h0, rb}, {8'h0, e});
        recv_byte(1'b1, rb);
        e = exp_rd.pop_front();
        chk("rd_byte1", {8'h0, rb}, {8'h0, e});
        tick(4);
        chk("rd_oe_after_nack", {15'h0, sda_oe}, 16'h0);
        chk("rd_busy_after_nack", {15'h0, busy}, 16'h0);
        i2c_stop();

        // Wrong address: the target must stay off the bus.
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        send_byte(8'hA8, a); chk("mm_addr_nack", {15'h0, a}, 16'h1);
        send_byte(8'h01, a); chk("mm_ptr_nack", {15'h0, a}, 16'h1);
        send_byte(8'h77, a); chk("mm_data_nack", {15'h0, a}, 16'h1);
        i2c_stop();
        chk("mm_oe_seen", {15'h0, oe_seen}, 16'h0);
        chk("mm_busy_seen", {15'h0, busy_seen}, 16'h0);
        dbg_chk("mm_reg1", 2'd1, 8'hA5);

        // STOP in the middle of the pointer byte.
        i2c_start();
        send_byte(8'hAA, a); chk("sm_addr_ack", {15'h0, a}, 16'h0);
        send_bits(8'h02, 4);
        i2c_stop();
        chk("sm_busy", {15'h0, busy}, 16'h0);
        chk("sm_oe", {15'h0, sda_oe}, 16'h0);
        i2c_start();
        send_byte(8'hAA, a); chk("sm2_addr_ack", {15'h0, a}, 16'h0);
        send_byte(8'h02, a);
        exp_wr.push_back({2'd2, 8'h5A});
        send_byte(8'h5A, a); chk("sm2_data_ack", {15'h0, a}, 16'h0);
        i2c_stop();
        dbg_chk("sm2_reg2", 2'd2, 8'h5A);

        // Reset while the target is pulling SDA low during a read.
        i2c_start();
        send_byte(8'hAA, a);
        send_byte(8'h02, a);
        i2c_start();
        send_byte(8'hAB, a); chk("rr_addr_ack", {15'h0, a}, 16'h0);
        n = 0;
        while (!sda_oe && n < 40) begin
            tick(1);
            n++;
        end
        chk("rr_oe_before_reset", {15'h0, sda_oe}, 16'h1);
        #2 reset = 1'b1;
        #1;
        chk("rr_oe_in_reset", {15'h0, sda_oe}, 16'h0);
        chk("rr_busy_in_reset", {15'h0, busy}, 16'h0);
        for (int i = 0; i < 4; i++) dbg_chk("rr_reg_cleared", 2'(i), 8'h00);
        sda_m = 1'b1;
        scl = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(10);

        // Normal operation after reset.
        i2c_start();
        send_byte(8'hAA, a); chk("pr_addr_ack", {15'h0, a}, 16'h0);
        send_byte(8'h00, a);
        exp_wr.push_back({2'd0, 8'h99});
        send_byte(8'h99, a); chk("pr_data_ack", {15'h0, a}, 16'h0);
        i2c_stop();
        dbg_chk("pr_reg0", 2'd0, 8'h99);
        tick(10);
        chk("wr_queue_drained", 16'(exp_wr.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
